// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the MEM/WB writeback stage: result-select codes,
// load funct3 codes and the default datapath width.
package writeback_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load formatter: picks the addressed byte/half from an aligned
// memory word and sign- or zero-extends it to XLEN.
module load_extend
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select; off[0] is ignored for halfwords since misalignment traps upstream.
  always_comb begin
    byte_s = raw[7:0];
    case (off)
      2'd0:    byte_s = raw[7:0];
      2'd1:    byte_s = raw[15:8];
      2'd2:    byte_s = raw[23:16];
      2'd3:    byte_s = raw[31:24];
      default: byte_s = raw[7:0];
    endcase
    if (off[1]) begin
      half_s = raw[31:16];
    end else begin
      half_s = raw[15:0];
    end
  end

  // Size/sign formatting; reserved encodings fall back to a full word.
  always_comb begin
    result = raw;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LH:   result = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_s};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_s};
      F3_LW:   result = raw;
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register and result selector driving the register-file write port.
// Define WB_INSTRET_EN to build the retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  output logic [4:0]       rd,
  output logic             writeEnable,
  output logic [XLEN-1:0]  writeData,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0] load_ext_s;
  logic [XLEN-1:0] result_s;
  logic            valid_r;
  logic            we_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] data_r;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (mem_funct3),
    .off    (mem_alu_result[1:0]),
    .raw    (mem_load_data),
    .result (load_ext_s)
  );

  // Result source select; 11 aliases the ALU path.
  always_comb begin
    result_s = mem_alu_result;
    case (mem_wb_sel)
      WB_LOAD: result_s = load_ext_s;
      WB_PC4:  result_s = mem_pc_plus4;
      WB_ALU:  result_s = mem_alu_result;
      default: result_s = mem_alu_result;
    endcase
  end

  // WB register; the write strobe is precomputed so x0 writes never leave the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      rd_r    <= 5'd0;
      data_r  <= {XLEN{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
    end else if (!stall) begin
      valid_r <= mem_valid;
      we_r    <= mem_valid & mem_reg_write & (mem_rd != 5'd0);
      rd_r    <= mem_rd;
      data_r  <= result_s;
    end
  end

  assign rd          = rd_r;
  assign writeEnable = we_r;
  assign writeData   = data_r;
  assign wb_valid    = valid_r;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_r;

  // Retire counter: every instruction accepted into WB counts, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (!flush && !stall && mem_valid) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign instret = instret_r;
`else
  assign instret = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected outputs,
// a monitor pops and compares one entry after each rising edge.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;
  logic [4:0]  rd;
  logic        writeEnable;
  logic [31:0] writeData;
  logic        wb_valid;
  logic [63:0] instret;

  typedef struct {
    logic        we;
    logic        v;
    logic        chkd;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [63:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic [63:0] exp_cnt   = 64'd0;
  logic [31:0] rf [32];

  writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc_plus4(mem_pc_plus4), .rd(rd), .writeEnable(writeEnable),
    .writeData(writeData), .wb_valid(wb_valid), .instret(instret)
  );

  always #5 clk = ~clk;

  // Downstream register file stand-in, written by the DUT's write port.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (writeEnable) begin
      rf[rd] <= writeData;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: one expected entry per rising edge that had stimulus behind it.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("writeEnable", {63'd0, writeEnable}, {63'd0, e.we});
      check("wb_valid", {63'd0, wb_valid}, {63'd0, e.v});
      check("instret", instret, e.cnt);
      if (e.chkd) begin
        check("rd", {59'd0, rd}, {59'd0, e.rd});
        check("writeData", {32'd0, writeData}, {32'd0, e.data});
      end
    end
  end

  task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                       input logic [4:0] r, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                       input logic e_we, input logic e_v, input logic e_chk,
                       input logic [4:0] e_rd, input logic [31:0] e_data);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; mem_valid = v; mem_reg_write = rw; mem_rd = r;
    mem_wb_sel = sel; mem_funct3 = f3; mem_alu_result = alu;
    mem_load_data = ld; mem_pc_plus4 = pc;
`ifdef WB_INSTRET_EN
    if (!fl && !st && v) exp_cnt = exp_cnt + 64'd1;
`endif
    e.we = e_we; e.v = e_v; e.chkd = e_chk; e.rd = e_rd; e.data = e_data; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, {63'd0, writeEnable}, 64'd0);
    check({tag, "_valid"}, {63'd0, wb_valid}, 64'd0);
    check({tag, "_rd"}, {59'd0, rd}, 64'd0);
    check({tag, "_data"}, {32'd0, writeData}, 64'd0);
    check({tag, "_instret"}, instret, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] raw;
    logic [4:0]  prev_rd;
    logic [31:0] prev_data;
    raw = 32'h80FF_7F01;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_reg_write = 1'b0;
    mem_rd = 5'd0; mem_wb_sel = 2'b00; mem_funct3 = 3'b000;
    mem_alu_result = 32'd0; mem_load_data = 32'd0; mem_pc_plus4 = 32'd0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // ALU, load formats, PC+4, select 11
    drive(0,0,1,1, 5'd5, 2'b00, 3'b010, 32'h1234_5678, raw, 32'd0, 1,1,1, 5'd5, 32'h1234_5678);
    drive(0,0,1,1, 5'd1, 2'b01, 3'b000, 32'h1000_0003, raw, 32'd0, 1,1,1, 5'd1, 32'hFFFF_FF80);
    drive(0,0,1,1, 5'd2, 2'b01, 3'b100, 32'h1000_0003, raw, 32'd0, 1,1,1, 5'd2, 32'h0000_0080);
    check("rf_x5", {32'd0, rf[5]}, {32'd0, 32'h1234_5678});
    drive(0,0,1,1, 5'd3, 2'b01, 3'b001, 32'h1000_0002, raw, 32'd0, 1,1,1, 5'd3, 32'hFFFF_80FF);
    drive(0,0,1,1, 5'd4, 2'b01, 3'b101, 32'h1000_0000, raw, 32'd0, 1,1,1, 5'd4, 32'h0000_7F01);
    drive(0,0,1,1, 5'd6, 2'b01, 3'b010, 32'h1000_0001, raw, 32'd0, 1,1,1, 5'd6, 32'h80FF_7F01);
    drive(0,0,1,1, 5'd8, 2'b01, 3'b011, 32'h1000_0003, raw, 32'd0, 1,1,1, 5'd8, 32'h80FF_7F01);
    drive(0,0,1,1, 5'd9, 2'b01, 3'b001, 32'h1000_0003, raw, 32'd0, 1,1,1, 5'd9, 32'hFFFF_80FF);
    drive(0,0,1,1, 5'd1, 2'b10, 3'b010, 32'h0000_0040, raw, 32'h0000_0104, 1,1,1, 5'd1, 32'h0000_0104);
    drive(0,0,1,1, 5'd10, 2'b11, 3'b010, 32'hA5A5_0000, raw, 32'h0000_0104, 1,1,1, 5'd10, 32'hA5A5_0000);
    // x0 suppression, no-reg-write, and a bubble
    drive(0,0,1,1, 5'd0, 2'b00, 3'b010, 32'hDEAD_BEEF, raw, 32'd0, 0,1,1, 5'd0, 32'hDEAD_BEEF);
    drive(0,0,1,0, 5'd11, 2'b00, 3'b010, 32'h0000_0B0B, raw, 32'd0, 0,1,1, 5'd11, 32'h0000_0B0B);
    drive(0,0,0,1, 5'd12, 2'b00, 3'b010, 32'h0000_0C0C, raw, 32'd0, 0,0,1, 5'd12, 32'h0000_0C0C);
    check("rf_x0", {32'd0, rf[0]}, 64'd0);

    // Stall holds for 3 cycles, then stall+flush invalidates
    drive(0,0,1,1, 5'd7, 2'b00, 3'b010, 32'h7777_0007, raw, 32'd0, 1,1,1, 5'd7, 32'h7777_0007);
    for (int i = 0; i < 3; i++)
      drive(1,0,1,1, 5'd20, 2'b00, 3'b010, 32'hFFFF_FFFF, raw, 32'd0, 1,1,1, 5'd7, 32'h7777_0007);
    drive(1,1,1,1, 5'd21, 2'b00, 3'b010, 32'h2121_2121, raw, 32'd0, 0,0,0, 5'd0, 32'd0);

    // Asynchronous reset between edges, held across an edge
    drive(0,0,1,1, 5'd13, 2'b00, 3'b010, 32'h1313_1313, raw, 32'd0, 1,1,1, 5'd13, 32'h1313_1313);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk);
    #1 check_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 64'd0;

    // Retire count: 10 captures, stalls at 3 and 7, flush at 10
    prev_rd = 5'd0; prev_data = 32'd0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3 || i == 7) begin
        drive(1,0,1,1, 5'd30, 2'b00, 3'b010, 32'hEEEE_EEEE, raw, 32'd0, 1,1,1, prev_rd, prev_data);
      end else if (i == 10) begin
        drive(0,1,1,1, 5'd30, 2'b00, 3'b010, 32'hEEEE_EEEE, raw, 32'd0, 0,0,0, 5'd0, 32'd0);
      end else begin
        prev_rd = 5'(i + 1);
        prev_data = 32'h0001_0000 + 32'(i);
        drive(0,0,1,1, prev_rd, 2'b00, 3'b010, prev_data, raw, 32'd0, 1,1,1, prev_rd, prev_data);
      end
    end
    drive(0,0,0,0, 5'd0, 2'b00, 3'b010, 32'd0, raw, 32'd0, 0,0,1, 5'd0, 32'd0);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
